// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file write-port arbiter between execute results and load returns
//
// Purpose: resolves the execute-path destination register, arbitrates the single
// register-file write port between load returns (which cannot stall) and execute
// results, queues losing execute results in an in-order FIFO, bounds their
// starvation with a forced FIFO grant, and exports a pending-write mask.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   ex_valid/ex_ready                 execute result handshake
//   ex_rd_select, ex_rt, ex_rd        destination select (0/3: rt, 1: rd, 2: $31)
//   ex_data                           execute result value
//   ld_valid, ld_dest, ld_data        load return (no backpressure)
//   rf_write_enable/reg/data          registered register-file write
//   pending_mask                      registers targeted by queued FIFO entries
//   fifo_count                        FIFO occupancy, 0..DEPTH

module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ex_valid,
    input  logic [1:0]                 ex_rd_select,
    input  logic [4:0]                 ex_rt,
    input  logic [4:0]                 ex_rd,
    input  logic [31:0]                ex_data,
    output logic                       ex_ready,
    input  logic                       ld_valid,
    input  logic [4:0]                 ld_dest,
    input  logic [31:0]                ld_data,
    output logic                       rf_write_enable,
    output logic [4:0]                 rf_write_reg,
    output logic [31:0]                rf_write_data,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // FIFO storage
    logic [4:0]    fifo_dest_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // One-entry load skid
    logic          skid_valid_q, skid_valid_d;
    logic [4:0]    skid_dest_q, skid_dest_d;
    logic [31:0]   skid_data_q, skid_data_d;

    logic [SW-1:0] starve_q, starve_d;

    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_reg_q, rf_reg_d;
    logic [31:0]   rf_data_q, rf_data_d;
    logic [31:0]   pending_q, pending_d;

    logic [4:0]    ex_dest;
    logic          ex_accept;
    logic          ld_live;
    logic          fifo_ne;
    logic          force_fifo;
    logic          gnt_skid, gnt_load, gnt_fifo, gnt_bypass;
    logic          push, pop;
    logic [PW-1:0] slot_off;
    logic [4:0]    slot_dest;

    always_comb begin
        case (ex_rd_select)
            2'd1:    ex_dest = ex_rd;
            2'd2:    ex_dest = 5'd31;
            default: ex_dest = ex_rt;
        endcase
    end

    assign ex_ready = (count_q != FULL_CNT);
    // Writes to $0 are handshaken normally but never reach the queue or the port.
    assign ex_accept  = ex_valid && ex_ready && (ex_dest != 5'd0);
    // A load arriving while the skid drains violates the bus contract and is dropped.
    assign ld_live    = ld_valid && (ld_dest != 5'd0) && !skid_valid_q;
    assign fifo_ne    = (count_q != '0);
    assign force_fifo = fifo_ne && (starve_q == STARVE_MAX);

    always_comb begin
        gnt_skid     = 1'b0;
        gnt_load     = 1'b0;
        gnt_fifo     = 1'b0;
        gnt_bypass   = 1'b0;
        skid_valid_d = 1'b0;
        skid_dest_d  = skid_dest_q;
        skid_data_d  = skid_data_q;
        // A starve-forced grant can never coincide with an occupied skid: the
        // force clears starve_cnt, so the skid drain sees it below the limit.
        if (skid_valid_q) begin
            gnt_skid = 1'b1;
        end else if (force_fifo) begin
            gnt_fifo = 1'b1;
            if (ld_live) begin
                skid_valid_d = 1'b1;
                skid_dest_d  = ld_dest;
                skid_data_d  = ld_data;
            end
        end else if (ld_live) begin
            gnt_load = 1'b1;
        end else if (fifo_ne) begin
            gnt_fifo = 1'b1;
        end else if (ex_accept) begin
            gnt_bypass = 1'b1;
        end
    end

    assign push = ex_accept && !gnt_bypass;
    assign pop  = gnt_fifo;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        if (pop || !fifo_ne) begin
            starve_d = '0;
        end else if ((gnt_load || gnt_skid) && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_comb begin
        rf_we_d   = gnt_skid || gnt_load || gnt_fifo || gnt_bypass;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;
        if (gnt_skid) begin
            rf_reg_d  = skid_dest_q;
            rf_data_d = skid_data_q;
        end else if (gnt_fifo) begin
            rf_reg_d  = fifo_dest_q[rd_ptr_q];
            rf_data_d = fifo_data_q[rd_ptr_q];
        end else if (gnt_load) begin
            rf_reg_d  = ld_dest;
            rf_data_d = ld_data;
        end else if (gnt_bypass) begin
            rf_reg_d  = ex_dest;
            rf_data_d = ex_data;
        end
    end

    // Mask reflects the FIFO contents after this cycle's push/pop so that it
    // stays aligned with fifo_count.
    always_comb begin
        pending_d = '0;
        slot_off  = '0;
        slot_dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off  = PW'(i) - rd_ptr_d;
            slot_dest = (push && (wr_ptr_q == PW'(i))) ? ex_dest : fifo_dest_q[i];
            if (CW'(slot_off) < count_d) begin
                pending_d[slot_dest] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest_q[wr_ptr_q] <= ex_dest;
            fifo_data_q[wr_ptr_q] <= ex_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_dest_q  <= '0;
            skid_data_q  <= '0;
            starve_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_reg_q     <= '0;
            rf_data_q    <= '0;
            pending_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            skid_valid_q <= skid_valid_d;
            skid_dest_q  <= skid_dest_d;
            skid_data_q  <= skid_data_d;
            starve_q     <= starve_d;
            rf_we_q      <= rf_we_d;
            rf_reg_q     <= rf_reg_d;
            rf_data_q    <= rf_data_d;
            pending_q    <= pending_d;
        end
    end

    assign rf_write_enable = rf_we_q;
    assign rf_write_reg    = rf_reg_q;
    assign rf_write_data   = rf_data_q;
    assign pending_mask    = pending_q;
    assign fifo_count      = count_q;

    // Loads must not return in the cycle the skid drains.
    a_no_load_on_skid_drain: assert property (@(posedge clk) disable iff (!reset_n)
        !(skid_valid_q && ld_valid));

endmodule
